ng_mem_seq: RTL and testbench

//  Parametrised successor to the combined memory/G-register/parity block. It owns an internal

---
 rtl/ng_mem_pkg.sv | 28 ++
 rtl/ng_par_gen.sv | 12 +
 rtl/ng_mem_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_ng_mem_seq.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ng_mem_pkg.sv
// Shared op codes, G shift-mode codes and sequencer state encoding for the memory
// sequencer slice.
package ng_mem_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_RESTORE = 2'd2,
        OP_RSVD    = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        GM_DIRECT = 3'd0,
        GM_CYR    = 3'd1,
        GM_SR     = 3'd2,
        GM_CYL    = 3'd3,
        GM_SL     = 3'd4
    } gmode_e;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRdWait = 3'd1,
        StCheck  = 3'd2,
        StWr     = 3'd3,
        StWb     = 3'd4
    } state_e;

endpackage

// File: rtl/ng_par_gen.sv
// Combinational single-bit parity generator, odd or even by parameter.
module ng_par_gen #(
    parameter int unsigned W       = 15,
    parameter bit          PAR_ODD = 1'b1
) (
    input  logic [W-1:0] data,
    output logic         par
);

    assign par = PAR_ODD ? ~^data : ^data;

endmodule

// File: rtl/ng_mem_seq.sv
// Memory sequencer: erasable RAM plus fixed-memory read port behind a valid/ready
// request interface, with per-word parity, the G register and a sticky parity alarm.
module ng_mem_seq
    import ng_mem_pkg::*;
#(
    parameter int unsigned DATA_W      = 15,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned ERAS_WORDS  = 1024,
    parameter int unsigned FIX_LAT     = 1,
    parameter bit          PAR_ODD     = 1'b1,
    parameter int unsigned PAR_CHK_MIN = 24,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              CLK2,
    input  logic              GENRST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [1:0]        REQ_OP,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              RSP_VALID,
    output logic              RSP_PERR,
    output logic              RSP_WERR,
    output logic [ADDR_W-1:0] FIX_ADDR,
    output logic              FIX_RD,
    input  logic [DATA_W:0]   FIX_DATA,
    input  logic              G_LD,
    input  logic [2:0]        G_MODE,
    input  logic [DATA_W-1:0] WRITE_BUS,
    output logic [DATA_W-1:0] G_OUT,
    input  logic              CLR_PALM,
    output logic              PALM,
    output logic [CNT_W-1:0]  PERR_CNT
);

    localparam int unsigned       MEM_AW   = (ERAS_WORDS > 1) ? $clog2(ERAS_WORDS) : 1;
    localparam int unsigned       LAT_W    = $clog2(FIX_LAT + 1);
    localparam logic [ADDR_W-1:0] ERAS_LIM = ADDR_W'(ERAS_WORDS);
    localparam logic [ADDR_W-1:0] CHK_LIM  = ADDR_W'(PAR_CHK_MIN);
    localparam logic [LAT_W-1:0]  FIX_WAIT = LAT_W'(FIX_LAT - 1);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                is_fix_q, is_fix_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                ram_we_q, ram_we_d;
    logic [DATA_W:0]     ram_wdata_q, ram_wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_perr_q, rsp_perr_d;
    logic                rsp_werr_q, rsp_werr_d;
    logic                fix_rd_q, fix_rd_d;
    logic [DATA_W-1:0]   g_q, g_d;
    logic                palm_q, palm_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [DATA_W:0]     mem [ERAS_WORDS];
    logic [DATA_W:0]     ram_rdata_q;
    logic [DATA_W:0]     rd_word;
    logic                wr_par;
    logic                chk_par;
    logic                req_fix;
    logic                perr;
    logic                g_ld_en;
    logic [DATA_W-1:0]   g_ld_val;

    ng_par_gen #(
        .W       (DATA_W),
        .PAR_ODD (PAR_ODD)
    ) u_par_wr (
        .data (REQ_WDATA),
        .par  (wr_par)
    );

    ng_par_gen #(
        .W       (DATA_W),
        .PAR_ODD (PAR_ODD)
    ) u_par_chk (
        .data (rd_word[DATA_W-1:0]),
        .par  (chk_par)
    );

    // Write and read both use the latched request address; the write only fires in WR/WB.
    always_ff @(posedge CLK2) begin
        if (ram_we_q) begin
            mem[addr_q[MEM_AW-1:0]] <= ram_wdata_q;
        end
        ram_rdata_q <= mem[addr_q[MEM_AW-1:0]];
    end

    assign req_fix = (REQ_ADDR >= ERAS_LIM);
    assign rd_word = is_fix_q ? FIX_DATA : ram_rdata_q;

    always_comb begin
        g_ld_en  = 1'b1;
        g_ld_val = WRITE_BUS;
        case (gmode_e'(G_MODE))
            GM_DIRECT: g_ld_val = WRITE_BUS;
            GM_CYR:    g_ld_val = {WRITE_BUS[0], WRITE_BUS[DATA_W-1:1]};
            GM_SR:     g_ld_val = {WRITE_BUS[DATA_W-1], WRITE_BUS[DATA_W-1:1]};
            GM_CYL:    g_ld_val = {WRITE_BUS[DATA_W-2:0], WRITE_BUS[DATA_W-1]};
            GM_SL:     g_ld_val = {WRITE_BUS[DATA_W-2:0], 1'b0};
            default:   g_ld_en  = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        is_fix_d    = is_fix_q;
        lat_d       = lat_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_perr_d  = 1'b0;
        rsp_werr_d  = 1'b0;
        fix_rd_d    = 1'b0;
        g_d         = g_q;
        palm_d      = palm_q;
        cnt_d       = cnt_q;
        perr        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (REQ_VALID) begin
                    op_d     = op_e'(REQ_OP);
                    addr_d   = REQ_ADDR;
                    is_fix_d = req_fix;
                    if (op_e'(REQ_OP) == OP_WRITE) begin
                        state_d     = StWr;
                        ram_we_d    = ~req_fix;
                        ram_wdata_d = {wr_par, REQ_WDATA};
                    end else begin
                        state_d  = StRdWait;
                        fix_rd_d = req_fix;
                        lat_d    = req_fix ? FIX_WAIT : '0;
                    end
                end else if (G_LD && g_ld_en) begin
                    g_d = g_ld_val;
                end
            end
            StRdWait: begin
                if (lat_q == '0) begin
                    state_d = StCheck;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            StCheck: begin
                rsp_valid_d = 1'b1;
                perr        = (rd_word[DATA_W] != chk_par) && (addr_q >= CHK_LIM) &&
                              (op_q != OP_RSVD);
                rsp_perr_d  = perr;
                if (op_q != OP_RSVD) begin
                    g_d = rd_word[DATA_W-1:0];
                end
                if (op_q == OP_RESTORE) begin
                    // Fresh parity on write-back repairs a flipped parity bit.
                    state_d     = StWb;
                    ram_we_d    = ~is_fix_q;
                    ram_wdata_d = {chk_par, rd_word[DATA_W-1:0]};
                end else begin
                    state_d = StIdle;
                end
            end
            StWr: begin
                rsp_valid_d = 1'b1;
                rsp_werr_d  = is_fix_q;
                state_d     = StIdle;
            end
            StWb: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (CLR_PALM) begin
            palm_d = 1'b0;
            cnt_d  = '0;
        end else if (perr) begin
            palm_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK2 or posedge GENRST) begin
        if (GENRST) begin
            state_q     <= StIdle;
            op_q        <= OP_READ;
            addr_q      <= '0;
            is_fix_q    <= 1'b0;
            lat_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_perr_q  <= 1'b0;
            rsp_werr_q  <= 1'b0;
            fix_rd_q    <= 1'b0;
            g_q         <= '0;
            palm_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            is_fix_q    <= is_fix_d;
            lat_q       <= lat_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_perr_q  <= rsp_perr_d;
            rsp_werr_q  <= rsp_werr_d;
            fix_rd_q    <= fix_rd_d;
            g_q         <= g_d;
            palm_q      <= palm_d;
            cnt_q       <= cnt_d;
        end
    end

    assign REQ_READY = (state_q == StIdle);
    assign RSP_VALID = rsp_valid_q;
    assign RSP_PERR  = rsp_perr_q;
    assign RSP_WERR  = rsp_werr_q;
    assign FIX_ADDR  = addr_q;
    assign FIX_RD    = fix_rd_q;
    assign G_OUT     = g_q;
    assign PALM      = palm_q;
    assign PERR_CNT  = cnt_q;

endmodule

// File: tb/tb_ng_mem_seq.sv
// Randomised self-checking bench for ng_mem_seq against a word-level reference model.
module tb_ng_mem_seq;

    localparam int FL = 3;

    logic        CLK2 = 1'b0;
    logic        GENRST = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [1:0]  REQ_OP = 2'd0;
    logic [11:0] REQ_ADDR = 12'd0;
    logic [14:0] REQ_WDATA = 15'd0;
    logic        RSP_VALID, RSP_PERR, RSP_WERR;
    logic [11:0] FIX_ADDR;
    logic        FIX_RD;
    logic [15:0] FIX_DATA;
    logic        G_LD = 1'b0;
    logic [2:0]  G_MODE = 3'd0;
    logic [14:0] WRITE_BUS = 15'd0;
    logic [14:0] G_OUT;
    logic        CLR_PALM = 1'b0;
    logic        PALM;
    logic [7:0]  PERR_CNT;

    int total = 0;
    int bad = 0;

    logic [15:0] ref_mem [1024];
    logic [14:0] g_ref = 15'd0;
    logic        palm_ref = 1'b0;
    int          cnt_ref = 0;

    ng_mem_seq #(
        .DATA_W      (15),
        .ADDR_W      (12),
        .ERAS_WORDS  (1024),
        .FIX_LAT     (FL),
        .PAR_ODD     (1'b1),
        .PAR_CHK_MIN (24),
        .CNT_W       (8)
    ) dut (
        .CLK2      (CLK2),
        .GENRST    (GENRST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_OP    (REQ_OP),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_PERR  (RSP_PERR),
        .RSP_WERR  (RSP_WERR),
        .FIX_ADDR  (FIX_ADDR),
        .FIX_RD    (FIX_RD),
        .FIX_DATA  (FIX_DATA),
        .G_LD      (G_LD),
        .G_MODE    (G_MODE),
        .WRITE_BUS (WRITE_BUS),
        .G_OUT     (G_OUT),
        .CLR_PALM  (CLR_PALM),
        .PALM      (PALM),
        .PERR_CNT  (PERR_CNT)
    );

    always #5 CLK2 = ~CLK2;

    function automatic logic par(input logic [14:0] d);
        return ~^d;
    endfunction

    // Fixed memory contents; words with addr[2:0]==7 carry a bad parity bit.
    function automatic logic [15:0] fix_word(input logic [11:0] a);
        logic [14:0] d;
        logic        p;
        d = {a[2:0], a} ^ 15'h2a5c;
        p = par(d);
        if (a[2:0] == 3'd7) p = ~p;
        return {p, d};
    endfunction

    function automatic logic [14:0] g_model(input logic [2:0] m, input logic [14:0] x,
                                            input logic [14:0] g);
        case (m)
            3'd0: return x;
            3'd1: return (x >> 1) | ((x & 15'h0001) << 14);
            3'd2: return (x >> 1) | (x & 15'h4000);
            3'd3: return ((x << 1) & 15'h7fff) | (x >> 14);
            3'd4: return (x << 1) & 15'h7fff;
            default: return g;
        endcase
    endfunction

    // External fixed memory: data presented FL cycles after the FIX_RD cycle, for one cycle.
    logic [11:0] fa [3];
    logic        fv [3] = '{default: 1'b0};
    always @(posedge CLK2) begin
        fa[0] <= FIX_ADDR;
        fv[0] <= FIX_RD;
        fa[1] <= fa[0];
        fv[1] <= fv[0];
        fa[2] <= fa[1];
        fv[2] <= fv[1];
    end
    assign FIX_DATA = fv[2] ? fix_word(fa[2]) : 16'h0000;

    task automatic model_op(input logic [1:0] op, input logic [11:0] a, input logic [14:0] wd,
                            input logic clr, output int lat, output logic perr,
                            output logic werr);
        logic [15:0] w;
        perr = 1'b0;
        werr = 1'b0;
        if (op == 2'd1) begin
            lat = 2;
            if (a >= 12'd1024) werr = 1'b1;
            else ref_mem[a[9:0]] = {par(wd), wd};
        end else begin
            lat = (a >= 12'd1024) ? 2 + FL : 3;
            w = (a >= 12'd1024) ? fix_word(a) : ref_mem[a[9:0]];
            if (op != 2'd3) begin
                perr = (w[15] != par(w[14:0])) && (a >= 12'd24);
                g_ref = w[14:0];
            end
            if (op == 2'd2 && a < 12'd1024) ref_mem[a[9:0]] = {par(w[14:0]), w[14:0]};
        end
        if (clr) begin
            palm_ref = 1'b0;
            cnt_ref = 0;
        end else if (perr) begin
            palm_ref = 1'b1;
            if (cnt_ref < 255) cnt_ref++;
        end
    endtask

    // Issues one request; lat=N means RSP_VALID was seen in the cycle ending at edge k+N.
    task automatic do_req(input logic [1:0] op, input logic [11:0] addr, input logic [14:0] wd,
                          output int lat, output logic perr, output logic werr);
        int guard;
        guard = 0;
        @(negedge CLK2);
        while (!REQ_READY && guard < 20) begin
            @(negedge CLK2);
            guard++;
        end
        REQ_VALID = 1'b1;
        REQ_OP = op;
        REQ_ADDR = addr;
        REQ_WDATA = wd;
        @(posedge CLK2);
        #1;
        REQ_VALID = 1'b0;
        lat = -1;
        perr = 1'b0;
        werr = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            if (RSP_VALID) begin
                lat = j;
                perr = RSP_PERR;
                werr = RSP_WERR;
                break;
            end
            @(posedge CLK2);
            #1;
        end
        for (int j = 0; j < 10; j++) begin
            if (REQ_READY) break;
            @(posedge CLK2);
            #1;
        end
    endtask

    task automatic backdoor_flip(input logic [9:0] a, input int b);
        ref_mem[a][b] = ~ref_mem[a][b];
        dut.mem[a] <= ref_mem[a];
    endtask

    task automatic test_reset;
        repeat (3) @(posedge CLK2);
        @(negedge CLK2);
        total += 6;
        if (REQ_READY !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", REQ_READY); end
        if (RSP_VALID !== 1'b0) begin bad++; $display("FAIL rst_rsp got=%b exp=0", RSP_VALID); end
        if (FIX_RD !== 1'b0) begin bad++; $display("FAIL rst_fixrd got=%b exp=0", FIX_RD); end
        if (G_OUT !== 15'd0) begin bad++; $display("FAIL rst_g got=%h exp=0", G_OUT); end
        if (PALM !== 1'b0) begin bad++; $display("FAIL rst_palm got=%b exp=0", PALM); end
        if (PERR_CNT !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%h exp=0", PERR_CNT); end
        GENRST = 1'b0;
    endtask

    task automatic test_write_read;
        int lat, elat;
        logic perr, werr, eperr, ewerr;
        model_op(2'd1, 12'd10, 15'h1234, 1'b0, elat, eperr, ewerr);
        do_req(2'd1, 12'd10, 15'h1234, lat, perr, werr);
        total += 2;
        if (lat !== 2) begin bad++; $display("FAIL wr_lat got=%0d exp=2", lat); end
        if (werr !== 1'b0) begin bad++; $display("FAIL wr_werr got=%b exp=0", werr); end
        model_op(2'd0, 12'd10, 15'h0, 1'b0, elat, eperr, ewerr);
        do_req(2'd0, 12'd10, 15'h0, lat, perr, werr);
        total += 3;
        if (lat !== 3) begin bad++; $display("FAIL rd_lat got=%0d exp=3", lat); end
        if (G_OUT !== 15'h1234) begin bad++; $display("FAIL rd_g got=%h exp=1234", G_OUT); end
        if (perr !== 1'b0) begin bad++; $display("FAIL rd_perr got=%b exp=0", perr); end
    endtask

    task automatic test_low_addr;
        int lat, elat;
        logic perr, werr, eperr, ewerr;
        @(negedge CLK2);
        backdoor_flip(10'd5, 15);
        model_op(2'd0, 12'd5, 15'h0, 1'b0, elat, eperr, ewerr);
        do_req(2'd0, 12'd5, 15'h0, lat, perr, werr);
        total += 3;
        if (perr !== 1'b0) begin bad++; $display("FAIL low_perr got=%b exp=0", perr); end
        if (PALM !== 1'b0) begin bad++; $display("FAIL low_palm got=%b exp=0", PALM); end
        if (G_OUT !== g_ref) begin bad++; $display("FAIL low_g got=%h exp=%h", G_OUT, g_ref); end
    endtask

    task automatic test_parity;
        int lat, elat;
        logic perr, werr, eperr, ewerr;
        @(negedge CLK2);
        backdoor_flip(10'd40, 15);
        model_op(2'd2, 12'd40, 15'h0, 1'b0, elat, eperr, ewerr);
        do_req(2'd2, 12'd40, 15'h0, lat, perr, werr);
        total += 4;
        if (perr !== 1'b1) begin bad++; $display("FAIL rs_perr got=%b exp=1", perr); end
        if (lat !== 3) begin bad++; $display("FAIL rs_lat got=%0d exp=3", lat); end
        if (PALM !== 1'b1) begin bad++; $display("FAIL rs_palm got=%b exp=1", PALM); end
        if (PERR_CNT !== 8'd1) begin bad++; $display("FAIL rs_cnt got=%h exp=1", PERR_CNT); end
        model_op(2'd0, 12'd40, 15'h0, 1'b0, elat, eperr, ewerr);
        do_req(2'd0, 12'd40, 15'h0, lat, perr, werr);
        total += 2;
        if (perr !== 1'b0) begin bad++; $display("FAIL rs_fixed got=%b exp=0", perr); end
        if (G_OUT !== g_ref) begin bad++; $display("FAIL rs_g got=%h exp=%h", G_OUT, g_ref); end
    endtask

    task automatic test_fixed;
        int lat, elat;
        logic perr, werr, eperr, ewerr;
        model_op(2'd1, 12'hC00, 15'h5555, 1'b0, elat, eperr, ewerr);
        do_req(2'd1, 12'hC00, 15'h5555, lat, perr, werr);
        total += 2;
        if (werr !== 1'b1) begin bad++; $display("FAIL fx_werr got=%b exp=1", werr); end
        if (lat !== 2) begin bad++; $display("FAIL fx_wlat got=%0d exp=2", lat); end
        // C00 aliases RAM index 0 in the low bits; it must stay untouched.
        model_op(2'd0, 12'd0, 15'h0, 1'b0, elat, eperr, ewerr);
        do_req(2'd0, 12'd0, 15'h0, lat, perr, werr);
        total += 1;
        if (G_OUT !== g_ref) begin bad++; $display("FAIL fx_noram got=%h exp=%h", G_OUT, g_ref); end
        model_op(2'd0, 12'hC00, 15'h0, 1'b0, elat, eperr, ewerr);
        do_req(2'd0, 12'hC00, 15'h0, lat, perr, werr);
        total += 3;
        if (lat !== 5) begin bad++; $display("FAIL fx_rlat got=%0d exp=5", lat); end
        if (G_OUT !== g_ref) begin bad++; $display("FAIL fx_g got=%h exp=%h", G_OUT, g_ref); end
        if (perr !== 1'b0) begin bad++; $display("FAIL fx_perr got=%b exp=0", perr); end
        model_op(2'd0, 12'hC07, 15'h0, 1'b0, elat, eperr, ewerr);
        do_req(2'd0, 12'hC07, 15'h0, lat, perr, werr);
        total += 2;
        if (perr !== 1'b1) begin bad++; $display("FAIL fx_bad got=%b exp=1", perr); end
        if (PERR_CNT !== 8'(cnt_ref)) begin bad++; $display("FAIL fx_cnt got=%h exp=%h", PERR_CNT, 8'(cnt_ref)); end
    endtask

    task automatic test_g_ld;
        logic [14:0] spec_exp [5];
        spec_exp = '{15'h4001, 15'h6000, 15'h6000, 15'h0003, 15'h0002};
        for (int m = 0; m < 6; m++) begin
            @(negedge CLK2);
            G_LD = 1'b1;
            G_MODE = 3'(m);
            WRITE_BUS = 15'h4001;
            g_ref = g_model(3'(m), 15'h4001, g_ref);
            @(posedge CLK2);
            #1;
            G_LD = 1'b0;
            total += 1;
            if (G_OUT !== g_ref) begin bad++; $display("FAIL gld_mode%0d got=%h exp=%h", m, G_OUT, g_ref); end
            if (m < 5) begin
                total += 1;
                if (G_OUT !== spec_exp[m]) begin bad++; $display("FAIL gld_vec%0d got=%h exp=%h", m, G_OUT, spec_exp[m]); end
            end
        end
    endtask

    task automatic test_g_drop;
        int elat;
        logic eperr, ewerr;
        for (int t = 0; t < 2; t++) begin
            @(negedge CLK2);
            G_LD = 1'b1;
            G_MODE = 3'd0;
            WRITE_BUS = 15'h7abc;
            REQ_VALID = 1'b1;
            REQ_OP = (t == 0) ? 2'd0 : 2'd3;
            REQ_ADDR = (t == 0) ? 12'd200 : 12'd300;
            model_op(REQ_OP, REQ_ADDR, 15'h0, 1'b0, elat, eperr, ewerr);
            @(posedge CLK2);
            #1;
            REQ_VALID = 1'b0;
            for (int j = 0; j < 20; j++) begin
                if (RSP_VALID) break;
                @(posedge CLK2);
                #1;
            end
            G_LD = 1'b0;
            total += 2;
            if (G_OUT !== g_ref) begin bad++; $display("FAIL gdrop%0d got=%h exp=%h", t, G_OUT, g_ref); end
            if (RSP_PERR !== 1'b0 || RSP_WERR !== 1'b0) begin
                bad++;
                $display("FAIL gdrop_err%0d got=%b%b exp=00", t, RSP_PERR, RSP_WERR);
            end
        end
    endtask

    task automatic test_clr;
        int lat, elat;
        logic perr, werr, eperr, ewerr;
        @(negedge CLK2);
        CLR_PALM = 1'b1;
        @(posedge CLK2);
        #1;
        CLR_PALM = 1'b0;
        palm_ref = 1'b0;
        cnt_ref = 0;
        total += 2;
        if (PALM !== 1'b0) begin bad++; $display("FAIL clr_palm got=%b exp=0", PALM); end
        if (PERR_CNT !== 8'd0) begin bad++; $display("FAIL clr_cnt got=%h exp=0", PERR_CNT); end
        CLR_PALM = 1'b1;
        model_op(2'd0, 12'hD0F, 15'h0, 1'b1, elat, eperr, ewerr);
        do_req(2'd0, 12'hD0F, 15'h0, lat, perr, werr);
        CLR_PALM = 1'b0;
        total += 3;
        if (perr !== 1'b1) begin bad++; $display("FAIL clrwin_perr got=%b exp=1", perr); end
        if (PALM !== 1'b0) begin bad++; $display("FAIL clrwin_palm got=%b exp=0", PALM); end
        if (PERR_CNT !== 8'd0) begin bad++; $display("FAIL clrwin_cnt got=%h exp=0", PERR_CNT); end
    endtask

    task automatic test_random;
        int lat, elat, r;
        logic perr, werr, eperr, ewerr;
        logic [1:0] op;
        logic [11:0] a;
        logic [14:0] wd;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) a = 12'($urandom_range(0, 63));
            else if (r < 7) a = 12'($urandom_range(0, 1023));
            else a = 12'($urandom_range(1024, 4095));
            op = 2'($urandom_range(0, 3));
            wd = 15'($urandom);
            if (a < 12'd1024 && $urandom_range(0, 5) == 0) backdoor_flip(a[9:0], $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge CLK2);
                G_LD = 1'b1;
                G_MODE = 3'($urandom_range(0, 7));
                WRITE_BUS = 15'($urandom);
                g_ref = g_model(G_MODE, WRITE_BUS, g_ref);
                @(posedge CLK2);
                #1;
                G_LD = 1'b0;
                total += 1;
                if (G_OUT !== g_ref) begin bad++; $display("FAIL rnd_gld i=%0d got=%h exp=%h", i, G_OUT, g_ref); end
            end
            model_op(op, a, wd, 1'b0, elat, eperr, ewerr);
            do_req(op, a, wd, lat, perr, werr);
            total += 1;
            if (lat !== elat || perr !== eperr || werr !== ewerr || G_OUT !== g_ref ||
                PALM !== palm_ref || PERR_CNT !== 8'(cnt_ref)) begin
                bad++;
                $display("FAIL rnd i=%0d op=%0d a=%h got lat=%0d p=%b w=%b g=%h palm=%b cnt=%h exp lat=%0d p=%b w=%b g=%h palm=%b cnt=%h",
                         i, op, a, lat, perr, werr, G_OUT, PALM, PERR_CNT,
                         elat, eperr, ewerr, g_ref, palm_ref, 8'(cnt_ref));
            end
        end
    endtask

    task automatic test_reset_mid;
        int lat, elat;
        logic perr, werr, eperr, ewerr;
        logic seen;
        @(negedge CLK2);
        REQ_VALID = 1'b1;
        REQ_OP = 2'd0;
        REQ_ADDR = 12'hC01;
        @(posedge CLK2);
        #1;
        REQ_VALID = 1'b0;
        @(negedge CLK2);
        GENRST = 1'b1;
        @(negedge CLK2);
        GENRST = 1'b0;
        g_ref = 15'd0;
        palm_ref = 1'b0;
        cnt_ref = 0;
        total += 2;
        if (REQ_READY !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", REQ_READY); end
        if (G_OUT !== 15'd0) begin bad++; $display("FAIL rmid_g got=%h exp=0", G_OUT); end
        seen = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(posedge CLK2);
            #1;
            if (RSP_VALID) seen = 1'b1;
        end
        total += 1;
        if (seen !== 1'b0) begin bad++; $display("FAIL rmid_rsp got=%b exp=0", seen); end
        // Reset while in WR must cancel the pending RAM write.
        @(negedge CLK2);
        REQ_VALID = 1'b1;
        REQ_OP = 2'd1;
        REQ_ADDR = 12'd100;
        REQ_WDATA = ~ref_mem[100][14:0];
        @(posedge CLK2);
        #1;
        REQ_VALID = 1'b0;
        GENRST = 1'b1;
        #2;
        GENRST = 1'b0;
        model_op(2'd0, 12'd100, 15'h0, 1'b0, elat, eperr, ewerr);
        do_req(2'd0, 12'd100, 15'h0, lat, perr, werr);
        total += 1;
        if (G_OUT !== g_ref) begin bad++; $display("FAIL rwr_cancel got=%h exp=%h", G_OUT, g_ref); end
    endtask

    task automatic test_saturate;
        int lat, elat;
        logic perr, werr, eperr, ewerr;
        logic [11:0] a;
        @(negedge CLK2);
        CLR_PALM = 1'b1;
        @(posedge CLK2);
        #1;
        CLR_PALM = 1'b0;
        palm_ref = 1'b0;
        cnt_ref = 0;
        for (int i = 0; i < 260; i++) begin
            a = {1'b1, 8'($urandom), 3'b111};
            model_op(2'd0, a, 15'h0, 1'b0, elat, eperr, ewerr);
            do_req(2'd0, a, 15'h0, lat, perr, werr);
            if (i == 253) begin
                total += 1;
                if (PERR_CNT !== 8'd254) begin bad++; $display("FAIL sat_254 got=%h exp=fe", PERR_CNT); end
            end
        end
        total += 2;
        if (PERR_CNT !== 8'hFF) begin bad++; $display("FAIL sat_ff got=%h exp=ff", PERR_CNT); end
        if (PALM !== 1'b1) begin bad++; $display("FAIL sat_palm got=%b exp=1", PALM); end
    endtask

    initial begin
        logic [14:0] w;
        for (int i = 0; i < 1024; i++) begin
            w = 15'($urandom);
            ref_mem[i] = {par(w), w};
            dut.mem[i] <= ref_mem[i];
        end
        test_reset();
        test_write_read();
        test_low_addr();
        test_parity();
        test_fixed();
        test_g_ld();
        test_g_drop();
        test_clr();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
